// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned DRAIN_CNT_W = 4;
  localparam int unsigned PERF_CNT_W  = 32;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard comparison between the load in EX and the instruction in ID.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] ifid_rs,
  input  logic [REG_IDX_W-1:0] ifid_rt,
  input  logic                 ifid_uses_rt,
  input  logic                 idex_memread,
  input  logic [REG_IDX_W-1:0] idex_dest,
  output logic                 load_use_c
);

  // Writes to the zero register never create a dependency.
  assign load_use_c = idex_memread && (idex_dest != ZERO_REG) &&
                      ((idex_dest == ifid_rs) ||
                       (ifid_uses_rt && (idex_dest == ifid_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard / program-end controller: stalls, branch flushes, fin drain and halt.
// Optional build macro HAZARD_CTRL_PERF_CNT_EN adds stall_cnt / flush_cnt outputs.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] ifid_rs,
  input  logic [REG_IDX_W-1:0] ifid_rt,
  input  logic                 ifid_uses_rt,
  input  logic                 ifid_fin,
  input  logic                 idex_memread,
  input  logic [REG_IDX_W-1:0] idex_dest,
  input  logic                 exmem_branch,
  input  logic                 exmem_zero,
  input  logic                 mem_wait,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 idex_write,
  output logic                 exmem_write,
  output logic                 memwb_write,
  output logic                 pc_src_branch,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic                 halted,
  output logic [1:0]           state_dbg
`ifdef HAZARD_CTRL_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

  hz_state_e              state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic                   load_use_c;
  logic                   branch_taken_c;

  hazard_detect u_hazard_detect (
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .idex_memread (idex_memread),
    .idex_dest    (idex_dest),
    .load_use_c   (load_use_c)
  );

  // A branch held in EX/MEM during a memory wait is simply applied once the wait ends.
  assign branch_taken_c = exmem_branch && exmem_zero && !mem_wait;
  assign state_dbg      = state_q;

  // State and drain counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state and combinational control outputs, priority mem_wait > branch > load-use > fin.
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    idex_write    = 1'b1;
    exmem_write   = 1'b1;
    memwb_write   = 1'b1;
    pc_src_branch = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    halted        = 1'b0;

    case (state_q)
      RUN, DRAIN: begin
        if (mem_wait) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          memwb_write = 1'b0;
        end else if (branch_taken_c) begin
          // Any fin behind the branch is on the wrong path; resume normal fetch.
          pc_src_branch = 1'b1;
          ifid_flush    = 1'b1;
          idex_flush    = 1'b1;
          exmem_flush   = 1'b1;
          state_d       = RUN;
          drain_cnt_d   = '0;
        end else if (state_q == DRAIN) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          if (drain_cnt_q == DRAIN_CNT_W'(DRAIN_CYCLES - 1)) begin
            state_d = HALT;
          end
          drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
        end else if (load_use_c) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end else if (ifid_fin) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      HALT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        memwb_write = 1'b0;
        halted      = 1'b1;
      end
      default: begin
        state_d     = RUN;
        drain_cnt_d = '0;
      end
    endcase
  end

`ifdef HAZARD_CTRL_PERF_CNT_EN
  logic stall_evt_c;
  logic flush_evt_c;

  assign stall_evt_c = (state_q == RUN) && !mem_wait && !branch_taken_c && load_use_c;
  assign flush_evt_c = ((state_q == RUN) || (state_q == DRAIN)) && branch_taken_c;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_CNT_W'(1);
      if (flush_evt_c && (flush_cnt != '1)) flush_cnt <= flush_cnt + PERF_CNT_W'(1);
    end
  end
`endif

endmodule
